// File: rtl/matrix_loader_pkg.sv
// matrix_loader_pkg: default configuration, derived sizes, FSM encoding and
// the chunk-alignment helper shared by the matrix loader files.
package matrix_loader_pkg;

   // Default build configuration (module parameters default to these)
   localparam int DEF_MAX_ROWS        = 64;
   localparam int DEF_MAX_COLS        = 64;
   localparam int DEF_BANDWIDTH       = 16;
   localparam int DEF_DATA_WIDTH      = 16;
   localparam int DEF_WORDS_PER_CYCLE = 4;

   // Sizes derived from the default configuration
   localparam int AW       = $clog2(DEF_MAX_ROWS * DEF_MAX_COLS);
   localparam int BEATS    = DEF_BANDWIDTH / DEF_WORDS_PER_CYCLE;
   localparam int OFFSET_W = $clog2(DEF_BANDWIDTH);

   // FSM encoding, kept as plain constants so older tools can consume it
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t FETCH = 2'd1;
   localparam state_t RESP  = 2'd2;

   // Clear the low offset_w bits of an address to get its chunk base.
   // Works on a 32-bit container so any address width can use it.
   function automatic logic [31:0] chunk_base(input logic [31:0] addr,
                                              input int unsigned offset_w);
      logic [31:0] mask;
      mask = '1;
      mask = mask << offset_w;
      return addr & mask;
   endfunction

endpackage

// File: rtl/matrix_loader_ram.sv
// weight_ram: simple dual-port weight store. One-word write port, a read port
// returning WORDS_PER_CYCLE consecutive words per access. The store is split
// into WORDS_PER_CYCLE banks (word a lives in bank a % WORDS_PER_CYCLE, row
// a / WORDS_PER_CYCLE) so every bank is a plain 1W/1R memory. Reads are
// registered and read-first: a same-cycle write to the read word is not seen.
module weight_ram #(
   parameter int DEPTH           = 4096,
   parameter int DATA_WIDTH      = 16,
   parameter int WORDS_PER_CYCLE = 4,
   parameter int AW              = $clog2(DEPTH),
   parameter int ROW_W           = AW - $clog2(WORDS_PER_CYCLE)
) (
   input  logic                                  clk,
   input  logic                                  i_wr_en,
   input  logic [AW-1:0]                         i_wr_addr,
   input  logic [DATA_WIDTH-1:0]                 i_wr_data,
   input  logic                                  i_rd_en,
   input  logic [ROW_W-1:0]                      i_rd_row,
   output logic [WORDS_PER_CYCLE*DATA_WIDTH-1:0] o_rd_data
);

   localparam int LANE_W = $clog2(WORDS_PER_CYCLE);
   localparam int ROWS   = DEPTH / WORDS_PER_CYCLE;

   genvar gi;
   generate
      for (gi = 0; gi < WORDS_PER_CYCLE; gi++) begin : g_bank
         logic [DATA_WIDTH-1:0] r_mem [ROWS];
         logic [DATA_WIDTH-1:0] r_rd;
         logic                  w_sel;
         logic [ROW_W-1:0]      w_wr_row;

         if (WORDS_PER_CYCLE == 1) begin : g_single
            assign w_sel    = 1'b1;
            assign w_wr_row = i_wr_addr;
         end else begin : g_multi
            assign w_sel    = (i_wr_addr[LANE_W-1:0] == LANE_W'(gi));
            assign w_wr_row = i_wr_addr[AW-1:LANE_W];
         end

         // Bank write and registered read (read-first on collision)
         always_ff @(posedge clk) begin
            if (i_wr_en && w_sel) begin
               r_mem[w_wr_row] <= i_wr_data;
            end
            if (i_rd_en) begin
               r_rd <= r_mem[i_rd_row];
            end
         end

         assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_rd;
      end
   endgenerate

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: responder for the matvec matrix-fetch interface. Host loads
// weights one word at a time; requests return a BANDWIDTH-word aligned chunk,
// fetched over BANDWIDTH/WORDS_PER_CYCLE RAM beats on a miss, or in one cycle
// when the chunk matches the single-entry cache.
module matrix_loader
   import matrix_loader_pkg::*;
#(
   parameter int MAX_ROWS        = DEF_MAX_ROWS,
   parameter int MAX_COLS        = DEF_MAX_COLS,
   parameter int BANDWIDTH       = DEF_BANDWIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int WORDS_PER_CYCLE = DEF_WORDS_PER_CYCLE,
   parameter int ADDR_W          = $clog2(MAX_ROWS * MAX_COLS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            weight_write_enable,
   input  logic [ADDR_W-1:0]               weight_write_addr,
   input  logic [DATA_WIDTH-1:0]           weight_write_data,
   input  logic [ADDR_W-1:0]               matrix_addr,
   input  logic                            matrix_enable,
   output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
   output logic                            matrix_ready,
   output logic                            busy
);

   localparam int          N_BEATS = BANDWIDTH / WORDS_PER_CYCLE;
   localparam int unsigned OFF_W   = $clog2(BANDWIDTH);
   localparam int          LANE_W  = $clog2(WORDS_PER_CYCLE);
   localparam int          ROW_W   = ADDR_W - LANE_W;
   localparam int          BEAT_W  = $clog2(N_BEATS + 1);
   localparam int          CHUNK_W = DATA_WIDTH * BANDWIDTH;
   localparam int          RD_W    = DATA_WIDTH * WORDS_PER_CYCLE;

   // Control state
   state_t              r_state;
   logic [BEAT_W-1:0]   r_beat;        // issue index; N_BEATS means "last data returning"
   logic [ADDR_W-1:0]   r_base;        // base of the current / cached chunk
   logic                r_cache_valid; // r_data holds mem[r_base +: BANDWIDTH]
   logic                r_dirty;       // in-flight chunk was written during the fetch

   // Data path
   logic [CHUNK_W-1:0]  r_chunk;       // assembly buffer, filled beat by beat
   logic [CHUNK_W-1:0]  r_data;        // last response (also the cached chunk)

   logic [ADDR_W-1:0]   w_req_base;
   logic [ADDR_W-1:0]   w_wr_base;
   logic                w_hit;
   logic                w_accept;
   logic                w_miss;
   logic                w_issue;
   logic                w_last;
   logic                w_wr_in_chunk;
   logic [ROW_W-1:0]    w_rd_row;
   logic [RD_W-1:0]     w_rd_data;
   logic [CHUNK_W-1:0]  w_assembled;

   assign w_req_base    = ADDR_W'(chunk_base(32'(matrix_addr), OFF_W));
   assign w_wr_base     = ADDR_W'(chunk_base(32'(weight_write_addr), OFF_W));

   assign w_accept      = (r_state == IDLE) && matrix_enable;
   assign w_hit         = r_cache_valid && (w_req_base == r_base);
   assign w_miss        = w_accept && !w_hit;

   // A read is issued for beats 0..N_BEATS-1; the extra cycle at N_BEATS
   // only collects the last returned words.
   assign w_issue       = (r_state == FETCH) && (r_beat < BEAT_W'(N_BEATS));
   assign w_last        = (r_state == FETCH) && (r_beat == BEAT_W'(N_BEATS));

   // Chunk-aligned base keeps beat*WORDS_PER_CYCLE within one RAM row step
   assign w_rd_row      = r_base[ADDR_W-1:LANE_W] + ROW_W'(r_beat);

   // A host write that lands in the chunk tracked by r_base
   assign w_wr_in_chunk = weight_write_enable && (w_wr_base == r_base);

   weight_ram #(
      .DEPTH           (MAX_ROWS * MAX_COLS),
      .DATA_WIDTH      (DATA_WIDTH),
      .WORDS_PER_CYCLE (WORDS_PER_CYCLE),
      .AW              (ADDR_W),
      .ROW_W           (ROW_W)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (weight_write_enable),
      .i_wr_addr (weight_write_addr),
      .i_wr_data (weight_write_data),
      .i_rd_en   (w_issue),
      .i_rd_row  (w_rd_row),
      .o_rd_data (w_rd_data)
   );

   // Data from the read issued at beat b appears while r_beat == b+1; route
   // it into its lanes and keep every other lane as already assembled.
   genvar gi;
   generate
      for (gi = 0; gi < BANDWIDTH; gi++) begin : g_lane
         localparam int SRC_WORD = gi % WORDS_PER_CYCLE;
         localparam int SRC_BEAT = gi / WORDS_PER_CYCLE;
         assign w_assembled[gi*DATA_WIDTH +: DATA_WIDTH] =
            (r_beat == BEAT_W'(SRC_BEAT + 1)) ? w_rd_data[SRC_WORD*DATA_WIDTH +: DATA_WIDTH]
                                              : r_chunk[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // FSM: accept in IDLE, sequence fetch beats, one-cycle RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_base  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (matrix_enable) begin
                  r_base  <= w_req_base;
                  r_beat  <= '0;
                  r_state <= w_hit ? RESP : FETCH;
               end
            end
            FETCH: begin
               if (w_last) begin
                  r_state <= RESP;
               end else begin
                  r_beat <= r_beat + BEAT_W'(1);
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Cache validity: set by a clean completed fetch, cleared by new misses
   // and by any host write into the tracked chunk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cache_valid <= 1'b0;
         r_dirty       <= 1'b0;
      end else if (w_miss) begin
         r_cache_valid <= 1'b0;
         r_dirty       <= 1'b0;
      end else if (w_last) begin
         // A write in the completion cycle also makes the chunk stale
         r_cache_valid <= !(r_dirty || w_wr_in_chunk);
      end else if (w_wr_in_chunk) begin
         r_cache_valid <= 1'b0;
         if (r_state == FETCH) begin
            r_dirty <= 1'b1;
         end
      end
   end

   // Chunk assembly during FETCH; output updates only when the fetch completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chunk <= '0;
         r_data  <= '0;
      end else if (r_state == FETCH) begin
         r_chunk <= w_assembled;
         if (w_last) begin
            r_data <= w_assembled;
         end
      end
   end

   assign matrix_data  = r_data;
   assign matrix_ready = (r_state == RESP);
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed, table-driven check of matrix_loader with a
// reference copy of the weight memory for expected chunk contents.
module tb_matrix_loader;

   localparam int DW = 16;
   localparam int BW = 16;
   localparam int CW = DW * BW;

   logic          clk = 1'b0;
   logic          rst;
   logic          weight_write_enable;
   logic [11:0]   weight_write_addr;
   logic [DW-1:0] weight_write_data;
   logic [11:0]   matrix_addr;
   logic          matrix_enable;
   logic [CW-1:0] matrix_data;
   logic          matrix_ready;
   logic          busy;

   matrix_loader dut (
      .clk                 (clk),
      .rst                 (rst),
      .weight_write_enable (weight_write_enable),
      .weight_write_addr   (weight_write_addr),
      .weight_write_data   (weight_write_data),
      .matrix_addr         (matrix_addr),
      .matrix_enable       (matrix_enable),
      .matrix_data         (matrix_data),
      .matrix_ready        (matrix_ready),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] model_mem [4096];

   // One request record: optional host write (wr_k: -1 none, 0 before the
   // request, k>0 during cycle k after acceptance), expected latency and an
   // optional single-lane spot check.
   typedef struct {
      logic [11:0]   addr;
      int            hold;
      int            wr_k;
      logic [11:0]   wa;
      logic [DW-1:0] wd;
      int            exp_lat;
      int            lane;
      logic [DW-1:0] lane_val;
   } vec_t;

   vec_t vecs [6];

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_chunk(input logic [11:0] addr);
      logic [CW-1:0] r;
      logic [11:0]   base;
      base = {addr[11:4], 4'h0};
      for (int i = 0; i < BW; i++) begin
         r[i*DW +: DW] = model_mem[base + 12'(i)];
      end
      return r;
   endfunction

   // Single host write; starts and ends at a falling edge
   task automatic wr_word(input logic [11:0] a, input logic [DW-1:0] d);
      weight_write_enable = 1'b1;
      weight_write_addr   = a;
      weight_write_data   = d;
      model_mem[a]        = d;
      @(negedge clk);
      weight_write_enable = 1'b0;
   endtask

   // Issue one request and watch exp_lat+1 cycles after acceptance
   task automatic do_req(input vec_t v, input string tag);
      int            first_k;
      int            pulses;
      int            busy_ok;
      logic [CW-1:0] got;
      if (v.wr_k == 0) begin
         wr_word(v.wa, v.wd);
      end
      matrix_addr   = v.addr;
      matrix_enable = 1'b1;
      @(posedge clk);
      first_k = 0;
      pulses  = 0;
      busy_ok = 1;
      got     = '0;
      for (int k = 1; k <= v.exp_lat + 1; k++) begin
         @(negedge clk);
         if (k == v.hold) matrix_enable = 1'b0;
         if (k == v.wr_k) begin
            weight_write_enable = 1'b1;
            weight_write_addr   = v.wa;
            weight_write_data   = v.wd;
            model_mem[v.wa]     = v.wd;
         end else begin
            weight_write_enable = 1'b0;
         end
         if (matrix_ready === 1'b1) begin
            pulses++;
            if (first_k == 0) begin
               first_k = k;
               got     = matrix_data;
            end
         end
         if (busy !== (k <= v.exp_lat)) busy_ok = 0;
      end
      matrix_enable       = 1'b0;
      weight_write_enable = 1'b0;
      check_int({tag, "_latency"}, first_k, v.exp_lat);
      check_int({tag, "_pulses"}, pulses, 1);
      check_int({tag, "_busy"}, busy_ok, 1);
      check_vec({tag, "_data"}, got, exp_chunk(v.addr));
      if (v.lane >= 0) begin
         check_int({tag, "_lane"}, int'(got[v.lane*DW +: DW]), int'(v.lane_val));
      end
      $display("req %s addr=%h lat=%0d pulses=%0d lane0=%h lane15=%h",
               tag, v.addr, first_k, pulses, got[0 +: DW], got[15*DW +: DW]);
   endtask

   initial begin
      int   pulses;
      int   busy_seen;
      vec_t sv;

      vecs[0] = '{12'h013, 2, -1, 12'h000, 16'h0000, 6, -1, 16'h0000}; // cold miss
      vecs[1] = '{12'h01C, 1, -1, 12'h000, 16'h0000, 1, 12, 16'h001C}; // hit, same chunk
      vecs[2] = '{12'h010, 1,  0, 12'h015, 16'hBEEF, 6,  5, 16'hBEEF}; // write invalidates
      vecs[3] = '{12'h020, 1,  2, 12'h02F, 16'h1234, 6, 15, 16'h1234}; // write mid-fetch
      vecs[4] = '{12'h020, 1, -1, 12'h000, 16'h0000, 6, 15, 16'h1234}; // not cached after dirty fetch
      vecs[5] = '{12'h02A, 1, -1, 12'h000, 16'h0000, 1, 10, 16'h002A}; // clean refetch now cached

      rst                 = 1'b1;
      weight_write_enable = 1'b0;
      weight_write_addr   = '0;
      weight_write_data   = '0;
      matrix_addr         = '0;
      matrix_enable       = 1'b0;

      repeat (2) @(negedge clk);
      check_int("reset_ready", int'(matrix_ready), 0);
      check_int("reset_busy", int'(busy), 0);
      check_vec("reset_data", matrix_data, '0);
      rst = 1'b0;
      @(negedge clk);

      // Load mem[i] = i
      for (int i = 0; i < 4096; i++) begin
         weight_write_enable = 1'b1;
         weight_write_addr   = 12'(i);
         weight_write_data   = 16'(i);
         model_mem[i]        = 16'(i);
         @(negedge clk);
      end
      weight_write_enable = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset during fetch beat 2: no response, outputs cleared at once
      matrix_addr   = 12'h010;
      matrix_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      matrix_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_int("rst_pre_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      check_int("rst_busy", int'(busy), 0);
      check_int("rst_ready", int'(matrix_ready), 0);
      check_vec("rst_data", matrix_data, '0);
      @(negedge clk);
      rst       = 1'b0;
      pulses    = 0;
      busy_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (matrix_ready === 1'b1) pulses++;
         if (busy === 1'b1) busy_seen++;
      end
      check_int("rst_no_pulse", pulses, 0);
      check_int("rst_stays_idle", busy_seen, 0);
      $display("req rst_mid_fetch addr=010 pulses=%0d busy_cycles=%0d", pulses, busy_seen);
      sv = '{12'h010, 1, -1, 12'h000, 16'h0000, 6, 5, 16'hBEEF};
      do_req(sv, "after_rst");

      // Matvec-style sweep: rows 1..4, columns stepped by 4
      for (int row = 1; row <= 4; row++) begin
         for (int col = 0; col < 64; col += 4) begin
            sv = '{12'(row * 64 + col), 1, -1, 12'h000, 16'h0000,
                   ((col % 16) == 0) ? 6 : 1, -1, 16'h0000};
            do_req(sv, $sformatf("sweep_r%0d_c%0d", row, col));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
